// File: rtl/rfsoc_config.sv
// rfsoc_config
//   Definitions shared by the GPIO bit-serial configuration writer
//   (gpio_serial_writer) and the dac_driver receiver.
//
//   GPIO_SDATA_BIT            gpio_ctrl bit carrying serial data
//   GPIO_CYCLE_COUNT_CLK_BIT  gpio_ctrl bit clocking the cycle-count register
//   GPIO_MASK_CLK_BIT         gpio_ctrl bit clocking the mask register
//   gsw_state_t               gpio_serial_writer FSM state encoding
//   gsw_max4()                elaboration-time max of four ints
package rfsoc_config;

    localparam int GPIO_SDATA_BIT           = 0;
    localparam int GPIO_CYCLE_COUNT_CLK_BIT = 1;
    localparam int GPIO_MASK_CLK_BIT        = 2;

    typedef enum logic [2:0] {
        GSW_IDLE  = 3'd0,
        GSW_PRE   = 3'd1,
        GSW_SETUP = 3'd2,
        GSW_HIGH  = 3'd3,
        GSW_HOLD  = 3'd4,
        GSW_POST  = 3'd5
    } gsw_state_t;

    function automatic int gsw_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/gpio_serial_writer.sv
// gpio_serial_writer
//   Serializes one DATA_WIDTH-bit word (bit 0 first) onto the gpio_ctrl
//   bus for a dac_driver receiver, strobing either the cycle-count or the
//   mask shift clock, with select_out framing the whole transfer.
//
//   Optional build macro: GPIO_SERIAL_WRITER_GUARD_EN adds GUARD_CYCLES of
//   select-only padding before (PRE) and after (POST) the bit train.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   s_axis_tdata   word to send, bit 0 first
//   s_axis_tuser   target: 0 = cycle_count_clk, 1 = mask_clk
//   s_axis_tvalid  word valid
//   s_axis_tready  high only in IDLE (registered)
//   gpio_ctrl      sdata / cycle_count_clk / mask_clk, other bits 0
//   select_out     high for the whole transfer
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the transfer ends
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a word, tready high
// PRE   | guard padding: select high, sdata and clocks low (macro only)
// SETUP | sdata driven with the current bit, shift clocks low
// HIGH  | selected shift clock high, sdata held
// HOLD  | shift clocks low, sdata held; advances bit or ends transfer
// POST  | guard padding after the last bit (macro only)
module gpio_serial_writer
    import rfsoc_config::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int GPIO_WIDTH   = 16,
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [GPIO_WIDTH-1:0] gpio_ctrl,
    output logic                  select_out,
    output logic                  busy,
    output logic                  done
);

    localparam int PHASE_MAX = gsw_max4(SETUP_CYCLES, HIGH_CYCLES, HOLD_CYCLES, GUARD_CYCLES);
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int BW        = $clog2(DATA_WIDTH);

    localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] HIGH_LAST  = PW'(HIGH_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
`ifdef GPIO_SERIAL_WRITER_GUARD_EN
    localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYCLES - 1);
`endif

    gsw_state_t            state;
    logic [PW-1:0]         phase;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  target;

    // Builds the full gpio_ctrl word; every bit other than the three
    // protocol bits is forced to 0.
    function automatic logic [GPIO_WIDTH-1:0] gpio_word(
        input logic sdata,
        input logic cc_clk,
        input logic mask_clk
    );
        logic [GPIO_WIDTH-1:0] w;
        w = '0;
        w[GPIO_SDATA_BIT]           = sdata;
        w[GPIO_CYCLE_COUNT_CLK_BIT] = cc_clk;
        w[GPIO_MASK_CLK_BIT]        = mask_clk;
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= GSW_IDLE;
            phase         <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            target        <= 1'b0;
            s_axis_tready <= 1'b0;
            gpio_ctrl     <= '0;
            select_out    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                GSW_IDLE: begin
                    s_axis_tready <= 1'b1;
                    gpio_ctrl     <= '0;
                    select_out    <= 1'b0;
                    busy          <= 1'b0;
                    // tready is registered, so the first cycle out of
                    // reset never accepts.
                    if (s_axis_tvalid && s_axis_tready) begin
                        shreg         <= s_axis_tdata;
                        target        <= s_axis_tuser;
                        bit_idx       <= '0;
                        phase         <= '0;
                        s_axis_tready <= 1'b0;
                        select_out    <= 1'b1;
                        busy          <= 1'b1;
`ifdef GPIO_SERIAL_WRITER_GUARD_EN
                        state         <= GSW_PRE;
                        gpio_ctrl     <= '0;
`else
                        state         <= GSW_SETUP;
                        gpio_ctrl     <= gpio_word(s_axis_tdata[0], 1'b0, 1'b0);
`endif
                    end
                end

`ifdef GPIO_SERIAL_WRITER_GUARD_EN
                GSW_PRE: begin
                    if (phase == GUARD_LAST) begin
                        phase     <= '0;
                        state     <= GSW_SETUP;
                        gpio_ctrl <= gpio_word(shreg[0], 1'b0, 1'b0);
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
`endif

                GSW_SETUP: begin
                    if (phase == SETUP_LAST) begin
                        phase     <= '0;
                        state     <= GSW_HIGH;
                        gpio_ctrl <= gpio_word(shreg[0], ~target, target);
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                GSW_HIGH: begin
                    if (phase == HIGH_LAST) begin
                        phase     <= '0;
                        state     <= GSW_HOLD;
                        gpio_ctrl <= gpio_word(shreg[0], 1'b0, 1'b0);
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

                GSW_HOLD: begin
                    if (phase == HOLD_LAST) begin
                        phase <= '0;
                        if (bit_idx == BIT_LAST) begin
`ifdef GPIO_SERIAL_WRITER_GUARD_EN
                            state     <= GSW_POST;
                            gpio_ctrl <= '0;
`else
                            state         <= GSW_IDLE;
                            gpio_ctrl     <= '0;
                            select_out    <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            s_axis_tready <= 1'b1;
`endif
                        end else begin
                            // Next bit is shreg[1] before the shift lands;
                            // clocks are already low so sdata moves alone.
                            shreg     <= shreg >> 1;
                            bit_idx   <= bit_idx + BW'(1);
                            state     <= GSW_SETUP;
                            gpio_ctrl <= gpio_word(shreg[1], 1'b0, 1'b0);
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end

`ifdef GPIO_SERIAL_WRITER_GUARD_EN
                GSW_POST: begin
                    if (phase == GUARD_LAST) begin
                        phase         <= '0;
                        state         <= GSW_IDLE;
                        gpio_ctrl     <= '0;
                        select_out    <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        s_axis_tready <= 1'b1;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
`endif

                default: begin
                    state         <= GSW_IDLE;
                    phase         <= '0;
                    gpio_ctrl     <= '0;
                    select_out    <= 1'b0;
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_serial_writer.sv
module tb_gpio_serial_writer;
    import rfsoc_config::*;

    localparam int DW = 256;
    localparam int GW = 16;
`ifdef GPIO_SERIAL_WRITER_GUARD_EN
    localparam int GUARD = 4;
`else
    localparam int GUARD = 0;
`endif
    // Measured in clock edges from the accepting edge.
    localparam int FIRST_RISE = 2 + GUARD;
    localparam int DONE_LAT   = DW * 6 + 2 * GUARD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tuser = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [GW-1:0] gpio;
    logic          select_out;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    gpio_serial_writer dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (tdata),
        .s_axis_tuser (tuser),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .gpio_ctrl    (gpio),
        .select_out   (select_out),
        .busy         (busy),
        .done         (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples sdata on each rising shift clock and shifts
    // it in from the top, so after DW pulses bit 0 holds the first bit.
    logic [GW-1:0] prev_gpio = '0;
    logic [DW-1:0] cap_cc = '0;
    logic [DW-1:0] cap_mask = '0;
    int cc_pulses = 0, mask_pulses = 0, done_cnt = 0, last_done_cyc = 0;
    int hi_cnt = 0, width_bad = 0, race_bad = 0, invar_bad = 0;

    always @(negedge clk) begin
        prev_gpio <= gpio;
        if (gpio[GPIO_CYCLE_COUNT_CLK_BIT] === 1'b1 && prev_gpio[GPIO_CYCLE_COUNT_CLK_BIT] === 1'b0) begin
            cc_pulses <= cc_pulses + 1;
            cap_cc    <= {gpio[GPIO_SDATA_BIT], cap_cc[DW-1:1]};
        end
        if (gpio[GPIO_MASK_CLK_BIT] === 1'b1 && prev_gpio[GPIO_MASK_CLK_BIT] === 1'b0) begin
            mask_pulses <= mask_pulses + 1;
            cap_mask    <= {gpio[GPIO_SDATA_BIT], cap_mask[DW-1:1]};
        end
        if (gpio[GPIO_CYCLE_COUNT_CLK_BIT] === 1'b1 || gpio[GPIO_MASK_CLK_BIT] === 1'b1) begin
            hi_cnt <= hi_cnt + 1;
        end else begin
            if ((prev_gpio[GPIO_CYCLE_COUNT_CLK_BIT] === 1'b1 || prev_gpio[GPIO_MASK_CLK_BIT] === 1'b1)
                && hi_cnt != 2)
                width_bad <= width_bad + 1;
            hi_cnt <= 0;
        end
        if (gpio[GPIO_SDATA_BIT] !== prev_gpio[GPIO_SDATA_BIT] &&
            (gpio[GPIO_CYCLE_COUNT_CLK_BIT] !== prev_gpio[GPIO_CYCLE_COUNT_CLK_BIT] ||
             gpio[GPIO_MASK_CLK_BIT] !== prev_gpio[GPIO_MASK_CLK_BIT]))
            race_bad <= race_bad + 1;
        if ((gpio & ~16'h0007) != '0 || select_out !== busy || (busy === 1'b1 && tready === 1'b1) ||
            (gpio[GPIO_CYCLE_COUNT_CLK_BIT] === 1'b1 && gpio[GPIO_MASK_CLK_BIT] === 1'b1))
            invar_bad <= invar_bad + 1;
        if (done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Presents a word and returns the edge number on which it is accepted.
    task automatic start(input logic [DW-1:0] d, input logic u, input logic keep,
                         input logic [DW-1:0] d_next, input logic u_next,
                         output int acc, output logic ok);
        tdata  = d;
        tuser  = u;
        tvalid = 1'b1;
        ok     = 1'b0;
        acc    = 0;
        for (int i = 0; i < 20; i++) begin
            if (tready === 1'b1) begin
                acc = cyc + 1;
                ok  = 1'b1;
                break;
            end
            tick();
        end
        tick();
        if (keep) begin
            tdata = d_next;
            tuser = u_next;
        end else begin
            tvalid = 1'b0;
            tdata  = ~d;
            tuser  = ~u;
        end
    endtask

    task automatic wait_done(input int base, output int dcyc, output logic ok);
        ok   = 1'b0;
        dcyc = 0;
        for (int i = 0; i < DONE_LAT + 100; i++) begin
            if (done_cnt > base) begin
                ok   = 1'b1;
                dcyc = last_done_cyc;
                break;
            end
            tick();
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          user;
        int            exp_cc;
        int            exp_mask;
        logic [DW-1:0] exp_word;
    } vec_t;

    localparam int NV = 5;
    vec_t vec [NV];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc2, dcyc, fr;
        logic ok;
        int s_cc, s_mk, s_dn, s_w, s_r;

        vec[0] = '{256'hA5, 1'b0, 256, 0, 256'hA5};
        vec[1] = '{{1'b0, {255{1'b1}}}, 1'b1, 0, 256, {1'b0, {255{1'b1}}}};
        vec[2] = '{{1'b1, 254'h0, 1'b1}, 1'b0, 256, 0, {1'b1, 254'h0, 1'b1}};
        vec[3] = '{256'h0, 1'b1, 0, 256, 256'h0};
        vec[4] = '{{8{32'hDEADBEEF}}, 1'b1, 0, 256, {8{32'hDEADBEEF}}};

        // Reset values
        rst = 1'b0;
        repeat (5) tick();
        chk_i("rst_gpio", int'(gpio), 0);
        chk_i("rst_select", int'(select_out), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_tready", int'(tready), 0);
        rst = 1'b1;
        tick();
        chk_i("tready_after_rst", int'(tready), 1);

        // Table-driven transfers
        for (int i = 0; i < NV; i++) begin
            s_cc = cc_pulses; s_mk = mask_pulses; s_dn = done_cnt;
            s_w = width_bad; s_r = race_bad;
            start(vec[i].data, vec[i].user, 1'b0, '0, 1'b0, acc, ok);
            chk_i($sformatf("v%0d_accept", i), int'(ok), 1);
            fr = -1;
            for (int k = 0; k < 20; k++) begin
                if (gpio[GPIO_CYCLE_COUNT_CLK_BIT] === 1'b1 || gpio[GPIO_MASK_CLK_BIT] === 1'b1) begin
                    fr = cyc;
                    break;
                end
                tick();
            end
            chk_i($sformatf("v%0d_first_rise", i), fr - acc, FIRST_RISE);
            chk_i($sformatf("v%0d_flags_mid", i), int'({select_out, busy, tready}), 6);
            wait_done(s_dn, dcyc, ok);
            chk_i($sformatf("v%0d_done_seen", i), int'(ok), 1);
            chk_i($sformatf("v%0d_done_lat", i), dcyc - acc, DONE_LAT);
            chk_i($sformatf("v%0d_cc_pulses", i), cc_pulses - s_cc, vec[i].exp_cc);
            chk_i($sformatf("v%0d_mask_pulses", i), mask_pulses - s_mk, vec[i].exp_mask);
            chk($sformatf("v%0d_word", i), vec[i].user ? cap_mask : cap_cc, vec[i].exp_word);
            chk_i($sformatf("v%0d_width", i), width_bad - s_w, 0);
            chk_i($sformatf("v%0d_race", i), race_bad - s_r, 0);
            repeat (3) tick();
            chk_i($sformatf("v%0d_done_once", i), done_cnt - s_dn, 1);
        end

        // Back-to-back: second word accepted on the done cycle
        s_dn = done_cnt; s_mk = mask_pulses;
        start(256'h1234_5678, 1'b0, 1'b1, 256'hCAFE_F00D, 1'b1, acc, ok);
        chk_i("b2b_accept1", int'(ok), 1);
        wait_done(s_dn, dcyc, ok);
        chk_i("b2b_done1", int'(ok), 1);
        chk_i("b2b_gap_select", int'(select_out), 0);
        chk_i("b2b_gap_tready", int'(tready), 1);
        tick();
        acc2 = cyc;
        chk_i("b2b_select_back", int'({select_out, busy, done}), 6);
        tvalid = 1'b0;
        tdata  = '1;
        tuser  = 1'b0;
        chk("b2b_word1", cap_cc, 256'h1234_5678);
        wait_done(s_dn + 1, dcyc, ok);
        chk_i("b2b_done2", int'(ok), 1);
        chk_i("b2b_lat2", dcyc - acc2, DONE_LAT);
        chk("b2b_word2", cap_mask, 256'hCAFE_F00D);
        chk_i("b2b_mask_pulses", mask_pulses - s_mk, 256);

        // Mid-transfer reset around bit 100
        s_dn = done_cnt; s_cc = cc_pulses;
        start({4{64'hFEDC_BA98_7654_3210}}, 1'b0, 1'b0, '0, 1'b0, acc, ok);
        chk_i("mr_accept", int'(ok), 1);
        for (int k = 0; k < 1000; k++) begin
            if (cc_pulses - s_cc >= 100) break;
            tick();
        end
        chk_i("mr_reached_bit100", cc_pulses - s_cc, 100);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        chk_i("mr_outputs", int'({gpio, select_out, busy, done, tready}), 0);
        tick();
        rst = 1'b1;
        tick();
        chk_i("mr_tready", int'(tready), 1);
        repeat (1600) tick();
        chk_i("mr_no_done", done_cnt - s_dn, 0);

        s_dn = done_cnt;
        start(256'h0F0F_0000_ABCD, 1'b0, 1'b0, '0, 1'b0, acc, ok);
        chk_i("mr_next_accept", int'(ok), 1);
        wait_done(s_dn, dcyc, ok);
        chk_i("mr_next_done", int'(ok), 1);
        chk("mr_next_word", cap_cc, 256'h0F0F_0000_ABCD);

        tick();
        chk_i("invariants", invar_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_serial_writer.md
# gpio_serial_writer

Hardware transmitter for the GPIO bit-serial configuration protocol used to load the `dac_driver` cycle-count and mask registers. It accepts one DATA_WIDTH-bit word plus a target select over an AXI-Stream slave and serializes it onto a gpio_ctrl bus with a select strobe. The bit timing matches what the `dac_driver` receiver expects. It sits between an on-fabric sequencer and any `dac_driver` instance, replacing PS-driven GPIO bit-banging.

## Interface
- DATA_WIDTH, 256, bits per transfer.
- GPIO_WIDTH, 16, width of the gpio_ctrl bus.
- SETUP_CYCLES, 2, cycles sdata is stable before the shift clock rises (≥1).
- HIGH_CYCLES, 2, cycles the shift clock is held high (≥1).
- HOLD_CYCLES, 2, cycles after the shift clock falls before sdata may change (≥1).
- GUARD_CYCLES, 4, select-only padding before and after the bit train (≥1; used only with the macro).

- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  word to send; bit 0 is sent first.
- s_axis_tuser  in  1  target: 0 = cycle_count_clk, 1 = mask_clk.
- s_axis_tvalid  in  1  word valid.
- s_axis_tready  out  1  high only in IDLE.
- gpio_ctrl  out  GPIO_WIDTH  bits [sdata], [cycle_count_clk] and [mask_clk] are driven; all other bits are 0.
- select_out  out  1  high for the whole transfer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final HOLD phase.

## Operation
- States: IDLE, PRE (macro only), SETUP, HIGH, HOLD, POST (macro only).
- **IDLE:** s_axis_tready = 1.
  - On tvalid & tready, latch tdata and tuser, clear bit_idx, clear phase counter.
  - Next state is SETUP, or PRE when the macro is defined.
- **SETUP:** gpio_ctrl[sdata] = shreg[0]; both shift clocks are 0; lasts SETUP_CYCLES cycles.
- **HIGH:** gpio_ctrl[target clock] = 1; the other shift clock stays 0; sdata is unchanged; lasts HIGH_CYCLES cycles.
- **HOLD:** both shift clocks are 0; sdata is unchanged; lasts HOLD_CYCLES cycles.
  - At the end of HOLD: if bit_idx = DATA_WIDTH-1, end the transfer; otherwise shift shreg right by 1, increment bit_idx, and return to SETUP.
- **End of transfer:** the cycle after the last HOLD cycle has select_out = 0, busy = 0, done = 1, s_axis_tready = 1, and state IDLE.
  - A new word may be accepted in that same cycle.
- Counters:
  - Phase counter width is $clog2(max(SETUP,HIGH,HOLD,GUARD)+1).
  - bit_idx width is $clog2(DATA_WIDTH).
  - Neither counter wraps; bit_idx is compared for equality against DATA_WIDTH-1.
- tvalid while busy is ignored; tdata and tuser are sampled only at acceptance.
- All outputs are registered; no output combinationally depends on an input.

## Timing
- Acceptance at edge N → select_out = 1 and the first SETUP cycle both start at cycle N+1.
- Per bit: SETUP+HIGH+HOLD cycles (default 6). With defaults, the shift clock is high in cycles N+3 and N+4.
- Transfer length without the macro: DATA_WIDTH*(SETUP+HIGH+HOLD) cycles (default 1536). done appears at cycle N+1537.
- sdata changes only on the first SETUP cycle of each bit.
- A shift clock never toggles in the same cycle that sdata changes.
- **Reset:**
  - While rst = 0, all outputs are 0, s_axis_tready = 0, and state is IDLE.
  - Reset mid-transfer abandons the word: no done pulse, and select_out drops at the next edge.
  - s_axis_tready = 1 on the first cycle after rst returns to 1.

## Configuration
- Macro: GPIO_SERIAL_WRITER_GUARD_EN.
- **Defined:**
  - PRE holds select_out = 1 with sdata and clocks at 0 for GUARD_CYCLES before the first SETUP.
  - POST holds select_out = 1 for GUARD_CYCLES after the last HOLD.
  - Transfer length grows by 2*GUARD_CYCLES cycles.
- **Undefined:**
  - PRE and POST do not exist, and GUARD_CYCLES is unused.
  - select_out rises with the first SETUP cycle and falls with done.

## Structure
- The gpio bit indices sdata, cycle_count_clk and mask_clk come from the shared rfsoc_config package; the writer and `dac_driver` share them.
- A state enum typedef (gsw_state_t) is added to rfsoc_config.
- Single module, no sub-modules; the phase counter and shift register are inline.

## Test plan
- **Reset values:** hold rst = 0 for 5 cycles → gpio_ctrl = 0, select_out = 0, busy = 0, done = 0, tready = 0; tready = 1 one cycle after release.
- **Cycle-count load:** send tdata = 256'hA5 with tuser = 0 → exactly 256 cycle_count_clk pulses, each 2 cycles high, and no mask_clk activity.
  - A bench-side `dac_driver` instance captures cycle count = 'hA5.
  - done pulses once, 1536 cycles after acceptance.
- **Mask load:** send tdata = all ones except bit 255 = 0, with tuser = 1 → 256 mask_clk pulses; the sampled sdata is 1 for bits 0–254 and 0 for bit 255.
  - cycle_count_clk stays 0 throughout.
- **Back-to-back:** hold tvalid high with two words → the second is accepted on the done cycle, and select_out stays 0 for exactly that one cycle.
  - With the macro defined: select_out precedes the first shift clock by GUARD+SETUP cycles and trails the last one by HOLD+GUARD cycles.
- **Mid-transfer reset:** assert rst at bit 100 → all outputs are 0 on the next edge and no done pulse follows.
  - The following transfer completes with correct data.
